// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the bypassing register file.
// Holds default widths, the zero-register address and the port-slice helper.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  localparam int MAX_N_RD   = 4;
  localparam int MAX_ADDR_W = 16;
  localparam int ADDR_BUS_W = MAX_N_RD * MAX_ADDR_W;

  // Returns port k's aw-bit address from a packed address bus,
  // zero-extended to MAX_ADDR_W so any instance width can share it.
  function automatic logic [MAX_ADDR_W-1:0] port_addr(
    input logic [ADDR_BUS_W-1:0] bus,
    input int                    k,
    input int                    aw
  );
    logic [ADDR_BUS_W-1:0] sh;
    logic [MAX_ADDR_W-1:0] mask;
    sh   = bus >> (k * aw);
    mask = (MAX_ADDR_W'(1) << aw) - MAX_ADDR_W'(1);
    return sh[MAX_ADDR_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// In: clk, reset, wr_en/waddr (retire), sb_set/sb_addr (issue), rd_addr; out: rd_busy.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_BUS_W-1:0] addr_bus;

  assign addr_bus = ADDR_BUS_W'(rd_addr);

  // Set is applied after clear so a newly issued producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[waddr] = 1'b0;
    if (sb_set) busy_d[sb_addr] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // A same-cycle write-back hides the busy bit, matching the bypass.
  for (genvar k = 0; k < N_RD; k++) begin : g_port
    logic [ADDR_W-1:0] a;
    assign a = ADDR_W'(port_addr(addr_bus, k, ADDR_W));
    assign rd_busy[k] = busy_q[a] & ~(wr_en & (waddr == a));
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Multi-port integer register file with write bypass, zero reg and scoreboard.
// In: clk, reset, rd_addr, wr_en/r_type/wr_*_addr/wr_data, sb_set/sb_addr; out: rd_data, rd_busy.
module reg_file_bypass
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_RD    = 2,
  parameter int REG_OUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic                   wr_en,
  input  logic                   r_type,
  input  logic [ADDR_W-1:0]      wr_rt_addr,
  input  logic [ADDR_W-1:0]      wr_rd_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   sb_set,
  input  logic [ADDR_W-1:0]      sb_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (N_RD < 1 || N_RD > MAX_N_RD) begin : g_bad_n_rd
    $error("reg_file_bypass: N_RD must be in 1..4");
  end
  if (ADDR_W < 1 || ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
    $error("reg_file_bypass: ADDR_W out of range");
  end

  logic [ADDR_W-1:0]     waddr;
  logic                  wr_ok;
  logic                  sb_ok;
  logic [ADDR_BUS_W-1:0] addr_bus;

  assign waddr    = r_type ? wr_rd_addr : wr_rt_addr;
  assign wr_ok    = wr_en & (waddr != ADDR_W'(ZERO_REG));
  assign sb_ok    = sb_set & (sb_addr != ADDR_W'(ZERO_REG));
  assign addr_bus = ADDR_BUS_W'(rd_addr);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[waddr] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [N_RD-1:0] busy_sb;

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .waddr   (waddr),
    .sb_set  (sb_ok),
    .sb_addr (sb_addr),
    .rd_addr (rd_addr),
    .rd_busy (busy_sb)
  );

  logic [N_RD*DATA_W-1:0] data_c;
  logic [N_RD-1:0]        busy_c;

  // Combinational outputs are forced to 0 while reset is held so
  // a stray bypass during reset cannot leak through.
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;
    assign a   = ADDR_W'(port_addr(addr_bus, k, ADDR_W));
    assign byp = wr_ok & (waddr == a);
    assign data_c[k*DATA_W +: DATA_W] =
      reset                        ? '0      :
      byp                          ? wr_data :
      (a == ADDR_W'(ZERO_REG))     ? '0      :
      regs_q[a];
    assign busy_c[k] = busy_sb[k] & ~reset;
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [N_RD*DATA_W-1:0] rd_data_q;
    logic [N_RD*DATA_W-1:0] rd_data_d;
    logic [N_RD-1:0]        rd_busy_q;
    logic [N_RD-1:0]        rd_busy_d;

    always_comb begin
      rd_data_d = data_c;
      rd_busy_d = busy_c;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;
  end else begin : g_comb_out
    assign rd_data = data_c;
    assign rd_busy = busy_c;
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Scoreboard bench for reg_file_bypass: a 4-port combinational instance
// and a 2-port registered instance share stimulus and a reference model.
module tb_reg_file_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] rd_addr4;
  logic [9:0]  rd_addr2;
  logic [127:0] rd_data4;
  logic [3:0]  rd_busy4;
  logic [63:0] rd_data2;
  logic [1:0]  rd_busy2;
  logic        wr_en;
  logic        r_type;
  logic [4:0]  wr_rt_addr;
  logic [4:0]  wr_rd_addr;
  logic [31:0] wr_data;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [4:0]  ra [4];

  always #5 clk = ~clk;

  assign rd_addr4 = {ra[3], ra[2], ra[1], ra[0]};
  assign rd_addr2 = {ra[1], ra[0]};

  reg_file_bypass #(
    .DATA_W (32), .ADDR_W (5), .N_RD (4), .REG_OUT (0)
  ) dut (
    .clk (clk), .reset (reset),
    .rd_addr (rd_addr4), .rd_data (rd_data4), .rd_busy (rd_busy4),
    .wr_en (wr_en), .r_type (r_type),
    .wr_rt_addr (wr_rt_addr), .wr_rd_addr (wr_rd_addr),
    .wr_data (wr_data), .sb_set (sb_set), .sb_addr (sb_addr)
  );

  reg_file_bypass #(
    .DATA_W (32), .ADDR_W (5), .N_RD (2), .REG_OUT (1)
  ) dut_r (
    .clk (clk), .reset (reset),
    .rd_addr (rd_addr2), .rd_data (rd_data2), .rd_busy (rd_busy2),
    .wr_en (wr_en), .r_type (r_type),
    .wr_rt_addr (wr_rt_addr), .wr_rd_addr (wr_rd_addr),
    .wr_data (wr_data), .sb_set (sb_set), .sb_addr (sb_addr)
  );

  typedef struct {
    int           cyc;
    logic [127:0] d;
    logic [3:0]   b;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: architectural registers and pending bits.
  logic [31:0] mem [32];
  bit          bsy [32];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the combinational instance is checked in the cycle the
  // stimulus was issued; the registered one a cycle later.
  always @(negedge clk) begin
    exp_t e;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rd_data4[k*32 +: 32] !== e.d[k*32 +: 32]) begin
          errors++;
          $display("FAIL comb data p%0d cyc %0d: got %h exp %h",
                   k, e.cyc, rd_data4[k*32 +: 32], e.d[k*32 +: 32]);
        end
        checks++;
        if (rd_busy4[k] !== e.b[k]) begin
          errors++;
          $display("FAIL comb busy p%0d cyc %0d: got %b exp %b",
                   k, e.cyc, rd_busy4[k], e.b[k]);
        end
      end
    end
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      logic [63:0] xd;
      logic [1:0]  xb;
      e  = qb.pop_front();
      xd = reset ? 64'd0 : e.d[63:0];
      xb = reset ? 2'd0 : e.b[1:0];
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rd_data2[k*32 +: 32] !== xd[k*32 +: 32]) begin
          errors++;
          $display("FAIL reg data p%0d cyc %0d: got %h exp %h",
                   k, e.cyc, rd_data2[k*32 +: 32], xd[k*32 +: 32]);
        end
        checks++;
        if (rd_busy2[k] !== xb[k]) begin
          errors++;
          $display("FAIL reg busy p%0d cyc %0d: got %b exp %b",
                   k, e.cyc, rd_busy2[k], xb[k]);
        end
      end
    end
  end

  task automatic idle();
    reset  = 1'b0;
    wr_en  = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
    ra[0] = 5'(a0);
    ra[1] = 5'(a1);
    ra[2] = 5'(a2);
    ra[3] = 5'(a3);
  endtask

  task automatic wr(input bit rt, input int a, input logic [31:0] d);
    wr_en  = 1'b1;
    r_type = rt;
    if (rt) wr_rd_addr = 5'(a);
    else    wr_rt_addr = 5'(a);
    wr_data = d;
  endtask

  // Predict outputs for the current inputs, queue them, advance the
  // model across the coming edge, then move to just after that edge.
  task automatic step();
    exp_t e;
    int   wa;
    int   a;
    wa    = r_type ? int'(wr_rd_addr) : int'(wr_rt_addr);
    e.cyc = cyc;
    e.d   = '0;
    e.b   = '0;
    for (int k = 0; k < 4; k++) begin
      a = int'(ra[k]);
      if (!reset) begin
        if (wr_en && wa != 0 && wa == a) e.d[k*32 +: 32] = wr_data;
        else if (a != 0)                 e.d[k*32 +: 32] = mem[a];
        e.b[k] = bsy[a] && !(wr_en && wa == a);
      end
    end
    qa.push_back(e);
    qb.push_back(e);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = '0;
        bsy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wa != 0) mem[wa] = wr_data;
      if (wr_en) bsy[wa] = 1'b0;
      if (sb_set && sb_addr != 0) bsy[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_addr(input int wa);
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return wa;
    if (r < 7) return $urandom_range(0, 7);
    return $urandom_range(0, 31);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
    reset = 1'b1;
    wr_en = 1'b0; r_type = 1'b0; sb_set = 1'b0;
    wr_rt_addr = '0; wr_rd_addr = '0; wr_data = '0; sb_addr = '0;
    set_ra(0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    step();
    idle();

    for (int i = 0; i < 32; i++) begin
      set_ra(i, 31 - i, i, (i + 7) % 32);
      step();
    end

    wr(1'b1, 5, 32'hDEADBEEF); set_ra(5, 0, 5, 1); step();
    idle(); set_ra(5, 5, 5, 5); step();
    wr(1'b1, 0, 32'h1234); set_ra(0, 0, 5, 0); step();
    idle(); set_ra(0, 0, 0, 5); step();

    wr(1'b0, 7, 32'hA5A5A5A5); set_ra(0, 7, 7, 5); step();
    idle(); set_ra(7, 7, 0, 0); step();

    sb_set = 1'b1; sb_addr = 5'd9; set_ra(9, 9, 9, 9); step();
    idle(); step();
    wr(1'b1, 9, 32'h99); step();
    idle(); step();
    sb_set = 1'b1; sb_addr = 5'd9; wr(1'b0, 9, 32'h999); step();
    idle(); step();
    sb_set = 1'b1; sb_addr = 5'd0; step();
    idle(); set_ra(0, 9, 0, 0); step();

    sb_set = 1'b1; sb_addr = 5'd3; wr(1'b1, 3, 32'h11); set_ra(3, 3, 3, 3); step();
    idle(); reset = 1'b1; wr(1'b1, 3, 32'h55); step();
    idle(); step();
    wr(1'b0, 3, 32'h22); step();
    idle(); step();

    wr(1'b1, 1, 32'h1); step();
    wr(1'b0, 2, 32'h2); step();
    idle(); set_ra(1, 2, 1, 0); step();

    for (int n = 0; n < 3000; n++) begin
      int wa;
      reset      = ($urandom_range(0, 299) == 0);
      wr_en      = ($urandom_range(0, 1) == 1);
      r_type     = ($urandom_range(0, 1) == 1);
      wr_rt_addr = 5'($urandom_range(0, 7));
      wr_rd_addr = 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      sb_set     = ($urandom_range(0, 2) == 0);
      sb_addr    = 5'($urandom_range(0, 7));
      wa = r_type ? int'(wr_rd_addr) : int'(wr_rt_addr);
      set_ra(pick_addr(wa), pick_addr(wa), pick_addr(wa), pick_addr(wa));
      step();
    end

    idle();
    step();
    step();
    @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() > 1) begin
      errors++;
      $display("FAIL drain: got qa=%0d qb=%0d exp qa=0 qb<=1",
               qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
